// File: rtl/execute_unit.sv
// EX stage of the multi-cycle MIPS-subset core: ALU, branch/jump PC update and
// an optional iterative shift-add MULTU, enabled by defining EX_MULT_EN.
module execute_unit #(
   parameter int DATA_W = 8,
   parameter int PC_W = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic [5:0]        opcode,
   input  logic [5:0]        func,
   input  logic [4:0]        shamt,
   input  logic [DATA_W-1:0] rsv,
   input  logic [DATA_W-1:0] rtv,
   input  logic [15:0]       imm,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic [PC_W-1:0]   program_counter,
   output logic              busy,
   output logic              ex_done
);

   localparam logic [2:0] STATE_EX   = 3'd2;
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FUNC_SLL   = 6'h00;
   localparam logic [5:0] FUNC_SRL   = 6'h02;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_ADDU  = 6'h21;
   localparam logic [5:0] FUNC_SUBU  = 6'h23;
   localparam logic [5:0] FUNC_AND   = 6'h24;
   localparam logic [5:0] FUNC_OR    = 6'h25;
   localparam logic [5:0] FUNC_XOR   = 6'h26;
   localparam logic [5:0] FUNC_SLT   = 6'h2A;
   localparam logic [5:0] FUNC_SLTU  = 6'h2B;

   logic [DATA_W-1:0] result_q;
   logic              result_valid_q;
   logic [PC_W-1:0]   pc_q;
   logic              ex_done_q;

   logic [DATA_W-1:0] result_d;
   logic              result_valid_d;
   logic [PC_W-1:0]   pc_d;
   logic              start_mult_s;

   logic [DATA_W-1:0] imm_data_s;
   logic [PC_W-1:0]   imm_pc_s;
   logic [PC_W-1:0]   jmp_pc_s;
   logic [PC_W-1:0]   pc_inc_s;
   logic              shift_ok_s;

   assign imm_data_s = DATA_W'({{DATA_W{imm[15]}}, imm});
   assign imm_pc_s   = PC_W'({{PC_W{imm[15]}}, imm});
   assign jmp_pc_s   = PC_W'({{PC_W{1'b0}}, imm});
   assign pc_inc_s   = pc_q + PC_W'(1);
   assign shift_ok_s = ({27'd0, shamt} < 32'(DATA_W));

   // Single-cycle decode: next result, writeback flag and next PC
   always_comb begin
      result_d       = result_q;
      result_valid_d = 1'b0;
      pc_d           = pc_inc_s;
      start_mult_s   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            result_valid_d = 1'b1;
            case (func)
               FUNC_ADDU: result_d = rsv + rtv;
               FUNC_SUBU: result_d = rsv - rtv;
               FUNC_AND:  result_d = rsv & rtv;
               FUNC_OR:   result_d = rsv | rtv;
               FUNC_XOR:  result_d = rsv ^ rtv;
               FUNC_SLT:  result_d = {{(DATA_W-1){1'b0}}, ($signed(rsv) < $signed(rtv))};
               FUNC_SLTU: result_d = {{(DATA_W-1){1'b0}}, (rsv < rtv)};
               FUNC_SLL:  result_d = shift_ok_s ? (rtv << shamt) : '0;
               FUNC_SRL:  result_d = shift_ok_s ? (rtv >> shamt) : '0;
`ifdef EX_MULT_EN
               FUNC_MULTU: begin
                  result_valid_d = 1'b0;
                  start_mult_s   = 1'b1;
               end
`endif
               default:   result_valid_d = 1'b0;
            endcase
         end
         OP_ADDIU, OP_LW: begin
            result_d       = rsv + imm_data_s;
            result_valid_d = 1'b1;
         end
         OP_SW:  result_d = rsv + imm_data_s;
         OP_BEQ: begin
            if (rsv == rtv) pc_d = pc_q + imm_pc_s;
            else            pc_d = pc_inc_s;
         end
         OP_BNE: begin
            if (rsv != rtv) pc_d = pc_q + imm_pc_s;
            else            pc_d = pc_inc_s;
         end
         OP_J:    pc_d = jmp_pc_s;
         default: pc_d = pc_inc_s;
      endcase
   end

`ifdef EX_MULT_EN
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic              busy_q;
   logic [DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0] mplier_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mult_sum_s;

   assign mult_sum_s = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy       = busy_q;
`else
   assign busy       = 1'b0;
`endif

   // Architectural state, plus the shift-add multiplier when present
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q       <= '0;
         result_valid_q <= 1'b0;
         pc_q           <= RESET_PC;
         ex_done_q      <= 1'b0;
`ifdef EX_MULT_EN
         busy_q         <= 1'b0;
         mcand_q        <= '0;
         mplier_q       <= '0;
         acc_q          <= '0;
         cnt_q          <= '0;
`endif
      end else begin
         ex_done_q <= 1'b0;
`ifdef EX_MULT_EN
         if (busy_q) begin
            // Leaving EX mid-multiply drops the operation without side effects
            if (state != STATE_EX) begin
               busy_q <= 1'b0;
            end else if (cnt_q == CNT_W'(1)) begin
               busy_q         <= 1'b0;
               result_q       <= mult_sum_s;
               result_valid_q <= 1'b1;
               pc_q           <= pc_inc_s;
               ex_done_q      <= 1'b1;
            end else begin
               acc_q    <= mult_sum_s;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CNT_W'(1);
            end
         end else
`endif
         if (state == STATE_EX) begin
            if (start_mult_s) begin
`ifdef EX_MULT_EN
               busy_q         <= 1'b1;
               result_valid_q <= 1'b0;
               mcand_q        <= rsv;
               mplier_q       <= rtv;
               acc_q          <= '0;
               cnt_q          <= CNT_W'(DATA_W);
`endif
            end else begin
               result_q       <= result_d;
               result_valid_q <= result_valid_d;
               pc_q           <= pc_d;
               ex_done_q      <= 1'b1;
            end
         end
      end
   end

   assign result          = result_q;
   assign result_valid    = result_valid_q;
   assign program_counter = pc_q;
   assign ex_done         = ex_done_q;

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Parametrised successor of the single-cycle EX stage in the multi-cycle MIPS-subset core.
- Consumes decoded operands while the controller is in STATE_EX, produces the ALU result, and owns the program counter.
- Adds configurable datapath/PC widths, synchronous reset, logic/shift/unsigned-compare ops, jump, and an iterative multi-cycle MULTU.
- Adds a busy/done handshake so the controller can hold STATE_EX until the instruction completes.

Parameters:
- DATA_W, 8: width of operands and result.
- PC_W, 8: width of program_counter.
- RESET_PC, 0: program_counter value after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- state  in  3  controller state; the unit acts only when state == STATE_EX.
- opcode  in  6  instruction opcode (OP_* definitions).
- func  in  6  R-type function field (FUNC_* definitions).
- shamt  in  5  shift amount for SLL/SRL.
- rsv  in  DATA_W  rs operand value.
- rtv  in  DATA_W  rt operand value.
- imm  in  16  immediate field.
- result  out  DATA_W  registered result.
- result_valid  out  1  high when result is to be written back.
- program_counter  out  PC_W  registered PC.
- busy  out  1  a multi-cycle operation is in progress.
- ex_done  out  1  one-cycle pulse when the current EX instruction completes.

Behaviour:
- Reset: rst=1 at an edge sets result=0, result_valid=0, program_counter=RESET_PC, busy=0, ex_done=0, and clears the multiplier state. Reset wins over every other event.
- Outside STATE_EX, with busy=0, all outputs hold and ex_done=0.
- Accept: at an edge with state==STATE_EX and busy=0, the instruction is accepted.
- Single-cycle ops complete on the accept edge: result updated, result_valid set per op, program_counter updated, ex_done=1 for exactly one cycle.
- ADDU / SUBU: rsv+rtv and rsv−rtv, modulo 2^DATA_W.
- AND / OR / XOR: bitwise operation on rsv and rtv.
- SLT: signed compare; result is 1 or 0, zero-extended.
- SLTU: unsigned compare; result is 1 or 0, zero-extended.
- SLL / SRL: rtv shifted by shamt; shamt ≥ DATA_W yields 0.
- R-type ops require the matching func code; any mismatch is treated as an unknown op.
- ADDIU / LW / SW: rsv + sign-extended imm, truncated to DATA_W.
- Writeback for the ops above: result_valid=1 for all except SW, which sets result_valid=0. All of them set pc=pc+1.
- BEQ / BNE: if taken, pc = pc + sign-extended imm modulo 2^PC_W; otherwise pc+1. result_valid=0; result unchanged.
- J: pc = imm[PC_W-1:0]; result_valid=0.
- Unknown op: result_valid=0, pc+1, ex_done pulses. The core never hangs.
- MULTU, multi-cycle:
  - Accept edge E0: busy<=1, result_valid<=0, operands latched, iteration count = DATA_W.
  - Edges E1..E(DATA_W): one shift-add step per edge.
  - At E(DATA_W): busy<=0, result = low DATA_W bits of rsv×rtv, result_valid=1, pc+1, ex_done=1.
  - Total: DATA_W+1 edges from accept to completion.
- While busy=1, the opcode/operand inputs are ignored; the latched copies are used.
- Abort: if state leaves STATE_EX while busy=1, the multiply aborts at that edge. busy<=0, no result or PC update, ex_done stays 0, result_valid stays 0.
- ex_done is never high on two consecutive cycles for the same instruction. The controller leaves STATE_EX on the cycle after ex_done.
- Wrap-around: the PC wraps modulo 2^PC_W in all update paths.

Optional Feature:
- EX_MULT_EN defined: MULTU is executed as above and the multiplier logic is instantiated.
- EX_MULT_EN undefined: MULTU is treated as an unknown op (single cycle, result_valid=0, pc+1). busy is tied to 0 and no multiplier logic is instantiated.

Test Plan:
- Reset: pulse rst=1 for one cycle with state=STATE_EX and opcode ADDU → pc=0, result=0, result_valid=0, busy=0, ex_done=0; no instruction executes.
- ADDU with rsv=0xF0, rtv=0x20 at pc=0 → result=0x10, result_valid=1, pc=1, ex_done high exactly one cycle. SUBU with rsv=0x00, rtv=0x01 → result=0xFF.
- SLT with rsv=0x80, rtv=0x01 → result=0x01. SLTU with the same operands → result=0x00. SLL with rtv=0x81, shamt=1 → result=0x02.
- Branches and jump:
  - BEQ with rsv=rtv=5, imm=0xFFFE at pc=3 → pc=1, result_valid=0.
  - BNE with the same operands → pc=4.
  - BEQ at pc=0xFF, not taken → pc=0x00.
  - J with imm=0x0042 → pc=0x42.
- MULTU with EX_MULT_EN defined:
  - 13×11 → busy high for 8 cycles, then result=0x8F, result_valid=1, pc+1, one ex_done pulse.
  - 0xFF×0xFF → result=0x01.
  - Operands changed while busy → result unaffected.
- Abort and reset mid-multiply:
  - State leaves STATE_EX at cycle 4 of a MULTU → busy=0 next cycle; pc and result unchanged; no ex_done.
  - rst at cycle 4 of a MULTU → all outputs take their reset values.
  - With EX_MULT_EN undefined, MULTU → single-cycle, result_valid=0, pc+1.
